// File: rtl/rob_commit_unit_if.sv
// Retirement-port bundle between the ROB head and the commit unit.
//
// Purpose: carries the retire handshake, the head entry, the ROB empty
// flag, the architectural regfile write port, the store-buffer release
// handshake, trap/flush signalling and the retired-instruction count.
//
// Signals:
//   retire_valid        ROB -> commit   head entry valid
//   retire_entry        ROB -> commit   head entry (rob_entry_t)
//   retire_ready        commit -> ROB   head accepted this cycle
//   rob_empty           ROB -> commit   ROB empty status
//   rf_we/waddr/wdata   commit -> RF    architectural register write
//   store_commit_valid  commit -> SB    release oldest store
//   store_commit_ready  SB -> commit    store buffer accepts release
//   flush               commit -> all   global pipeline flush
//   trap_valid/epc/cause commit -> CSR  trap taken, its PC and cause
//   instret             commit -> CSR   retired-instruction count
//
// Modports: master = ROB/environment side, slave = commit unit.
interface rob_commit_unit_if #(
    parameter int XLEN = 32
);
    typedef logic [4:0] exception_code_t;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic             has_dest;
        logic [4:0]       dest_reg;
        logic [XLEN-1:0]  result;
        logic             exception;
        exception_code_t  exception_code;
        logic             is_store;
    } rob_entry_t;

    logic            retire_valid;
    rob_entry_t      retire_entry;
    logic            retire_ready;
    logic            rob_empty;

    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    logic            store_commit_valid;
    logic            store_commit_ready;

    logic            flush;
    logic            trap_valid;
    logic [XLEN-1:0] trap_epc;
    exception_code_t trap_cause;

    logic [63:0]     instret;

    modport master (
        output retire_valid, retire_entry, rob_empty, store_commit_ready,
        input  retire_ready, rf_we, rf_waddr, rf_wdata, store_commit_valid,
               flush, trap_valid, trap_epc, trap_cause, instret
    );

    modport slave (
        input  retire_valid, retire_entry, rob_empty, store_commit_ready,
        output retire_ready, rf_we, rf_waddr, rf_wdata, store_commit_valid,
               flush, trap_valid, trap_epc, trap_cause, instret
    );
endinterface

// File: rtl/rob_commit_unit.sv
// ROB commit unit: retires head entries in program order.
//
// Purpose: writes retiring results into the architectural register file,
// releases committed stores to the store buffer, turns an excepting entry
// into a one-cycle trap + flush and then waits for the ROB to drain, and
// counts retired instructions.
//
// Ports:
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset; all outputs forced to 0 while high
//   bus    rob_commit_unit_if.slave (see interface header for signal list)
//
// Timing: retire_ready and store_commit_valid are combinational; all other
// outputs are registered and appear the cycle after the retire handshake.
module rob_commit_unit #(
    parameter int CONFIG_XLEN     = 32,
    parameter int CONFIG_ROB_SIZE = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    rob_commit_unit_if.slave   bus
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        TRAP  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DRAIN_LIMIT = 4 * CONFIG_ROB_SIZE;
    localparam int DRAIN_W     = $clog2(DRAIN_LIMIT + 2);

    state_t                  state_reg, state_next;
    logic                    rf_we_reg, rf_we_next;
    logic [4:0]              rf_waddr_reg, rf_waddr_next;
    logic [CONFIG_XLEN-1:0]  rf_wdata_reg, rf_wdata_next;
    logic                    flush_reg, flush_next;
    logic                    trap_valid_reg, trap_valid_next;
    logic [CONFIG_XLEN-1:0]  trap_epc_reg, trap_epc_next;
    logic [4:0]              trap_cause_reg, trap_cause_next;
    logic [63:0]             instret_reg, instret_next;
    logic [DRAIN_W-1:0]      drain_cnt_reg, drain_cnt_next;

    logic                    retire_ready;
    logic                    store_commit_valid;
    logic                    head_store;

    // A non-excepting store at the head needs the store buffer to take it
    // in the same cycle, otherwise the head must stall.
    assign head_store = bus.retire_valid && bus.retire_entry.is_store
                        && !bus.retire_entry.exception;

    always_comb begin
        state_next         = state_reg;
        rf_we_next         = 1'b0;
        rf_waddr_next      = rf_waddr_reg;
        rf_wdata_next      = rf_wdata_reg;
        flush_next         = 1'b0;
        trap_valid_next    = 1'b0;
        trap_epc_next      = trap_epc_reg;
        trap_cause_next    = trap_cause_reg;
        instret_next       = instret_reg;
        drain_cnt_next     = '0;
        retire_ready       = 1'b0;
        store_commit_valid = 1'b0;

        case (state_reg)
            RUN: begin
                retire_ready       = !(head_store && !bus.store_commit_ready);
                store_commit_valid = head_store;
                if (bus.retire_valid && retire_ready) begin
                    if (bus.retire_entry.exception) begin
                        // Excepting entry does not count as retired.
                        state_next      = TRAP;
                        flush_next      = 1'b1;
                        trap_valid_next = 1'b1;
                        trap_epc_next   = bus.retire_entry.pc;
                        trap_cause_next = bus.retire_entry.exception_code;
                    end else begin
                        rf_we_next    = bus.retire_entry.has_dest
                                        && (bus.retire_entry.dest_reg != 5'd0);
                        rf_waddr_next = bus.retire_entry.dest_reg;
                        rf_wdata_next = bus.retire_entry.result;
                        instret_next  = instret_reg + 64'd1;
                    end
                end
            end
            TRAP: begin
                state_next = DRAIN;
            end
            DRAIN: begin
                // Saturating count of cycles spent draining.
                if (drain_cnt_reg != DRAIN_W'(DRAIN_LIMIT + 1))
                    drain_cnt_next = drain_cnt_reg + DRAIN_W'(1);
                else
                    drain_cnt_next = drain_cnt_reg;
                if (bus.rob_empty)
                    state_next = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= RUN;
            rf_we_reg      <= 1'b0;
            rf_waddr_reg   <= '0;
            rf_wdata_reg   <= '0;
            flush_reg      <= 1'b0;
            trap_valid_reg <= 1'b0;
            trap_epc_reg   <= '0;
            trap_cause_reg <= '0;
            instret_reg    <= '0;
            drain_cnt_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            rf_we_reg      <= rf_we_next;
            rf_waddr_reg   <= rf_waddr_next;
            rf_wdata_reg   <= rf_wdata_next;
            flush_reg      <= flush_next;
            trap_valid_reg <= trap_valid_next;
            trap_epc_reg   <= trap_epc_next;
            trap_cause_reg <= trap_cause_next;
            instret_reg    <= instret_next;
            drain_cnt_reg  <= drain_cnt_next;
        end
    end

    // Combinational outputs are gated so nothing is offered during reset.
    assign bus.retire_ready       = retire_ready && !rst_i;
    assign bus.store_commit_valid = store_commit_valid && !rst_i;
    assign bus.rf_we              = rf_we_reg;
    assign bus.rf_waddr           = rf_waddr_reg;
    assign bus.rf_wdata           = rf_wdata_reg;
    assign bus.flush              = flush_reg;
    assign bus.trap_valid         = trap_valid_reg;
    assign bus.trap_epc           = trap_epc_reg;
    assign bus.trap_cause         = trap_cause_reg;
    assign bus.instret            = instret_reg;

    // A drain that outlasts several ROB turnovers means the ROB never empties.
    a_drain_timeout: assert property (
        @(posedge clk_i) disable iff (rst_i)
        drain_cnt_reg <= DRAIN_W'(DRAIN_LIMIT)
    );

    // A stalled head in RUN must be held steady by the ROB until accepted.
    a_head_stable: assert property (
        @(posedge clk_i) disable iff (rst_i)
        (state_reg == RUN && bus.retire_valid && !retire_ready)
            |=> $stable(bus.retire_entry)
    );

endmodule

// File: tb/tb_rob_commit_unit.sv
module tb_rob_commit_unit;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    rob_commit_unit_if #(.XLEN(32)) bus ();

    rob_commit_unit #(
        .CONFIG_XLEN     (32),
        .CONFIG_ROB_SIZE (16)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a head entry (inputs only; checks are done by each test).
    task automatic set_entry(input logic [31:0] pc, input logic has_dest,
                             input logic [4:0] dest, input logic [31:0] result,
                             input logic exc, input logic [4:0] code,
                             input logic is_store);
        bus.retire_entry.pc             = pc;
        bus.retire_entry.has_dest       = has_dest;
        bus.retire_entry.dest_reg       = dest;
        bus.retire_entry.result         = result;
        bus.retire_entry.exception      = exc;
        bus.retire_entry.exception_code = code;
        bus.retire_entry.is_store       = is_store;
        bus.retire_valid                = 1'b1;
        $display("[TB] head pc=%h dest=x%0d result=%h exc=%0d code=%0d store=%0d",
                 pc, dest, result, exc, code, is_store);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.retire_valid = 1'b0;
        bus.retire_entry = '0;
        bus.rob_empty = 1'b0;
        bus.store_commit_ready = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus.retire_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %0h expected 0", bus.retire_ready); end
        tests_run++;
        if (bus.rf_we !== 1'b0 || bus.flush !== 1'b0 || bus.trap_valid !== 1'b0 || bus.store_commit_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_ctrl: got we=%0h fl=%0h tv=%0h scv=%0h expected all 0", bus.rf_we, bus.flush, bus.trap_valid, bus.store_commit_valid);
        end
        tests_run++;
        if (bus.instret !== 64'd0 || bus.trap_epc !== 32'd0 || bus.rf_wdata !== 32'd0) begin
            tests_failed++; $display("FAIL reset_data: got instret=%0h epc=%0h wdata=%0h expected 0", bus.instret, bus.trap_epc, bus.rf_wdata);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.retire_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_release_ready: got %0h expected 1", bus.retire_ready); end
    endtask

    task automatic test_alu();
        set_entry(32'h1000, 1'b1, 5'd1, 32'd10, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        bus.retire_valid = 1'b0;
        tests_run++;
        if (bus.rf_we !== 1'b1) begin tests_failed++; $display("FAIL alu_we: got %0h expected 1", bus.rf_we); end
        tests_run++;
        if (bus.rf_waddr !== 5'd1 || bus.rf_wdata !== 32'd10) begin
            tests_failed++; $display("FAIL alu_wdata: got addr=%0d data=%0d expected addr=1 data=10", bus.rf_waddr, bus.rf_wdata);
        end
        tests_run++;
        if (bus.instret !== 64'd1) begin tests_failed++; $display("FAIL alu_instret: got %0d expected 1", bus.instret); end
        @(negedge clk);
        tests_run++;
        if (bus.rf_we !== 1'b0 || bus.instret !== 64'd1) begin
            tests_failed++; $display("FAIL alu_idle: got we=%0h instret=%0d expected we=0 instret=1", bus.rf_we, bus.instret);
        end
    endtask

    task automatic test_x0();
        set_entry(32'h1004, 1'b1, 5'd0, 32'd55, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        set_entry(32'h1008, 1'b0, 5'd7, 32'd77, 1'b0, 5'd0, 1'b0);
        tests_run++;
        if (bus.rf_we !== 1'b0 || bus.instret !== 64'd2) begin
            tests_failed++; $display("FAIL x0_write: got we=%0h instret=%0d expected we=0 instret=2", bus.rf_we, bus.instret);
        end
        @(negedge clk);
        bus.retire_valid = 1'b0;
        tests_run++;
        if (bus.rf_we !== 1'b0 || bus.instret !== 64'd3) begin
            tests_failed++; $display("FAIL nodest_write: got we=%0h instret=%0d expected we=0 instret=3", bus.rf_we, bus.instret);
        end
    endtask

    task automatic test_store_stall();
        bus.store_commit_ready = 1'b0;
        set_entry(32'h2000, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (bus.retire_ready !== 1'b0 || bus.store_commit_valid !== 1'b1 || bus.instret !== 64'd3) begin
                tests_failed++; $display("FAIL store_stall[%0d]: got rdy=%0h scv=%0h instret=%0d expected rdy=0 scv=1 instret=3", i, bus.retire_ready, bus.store_commit_valid, bus.instret);
            end
            @(negedge clk);
        end
        bus.store_commit_ready = 1'b1;
        #1;
        tests_run++;
        if (bus.retire_ready !== 1'b1 || bus.store_commit_valid !== 1'b1) begin
            tests_failed++; $display("FAIL store_accept: got rdy=%0h scv=%0h expected 1 1", bus.retire_ready, bus.store_commit_valid);
        end
        @(negedge clk);
        bus.retire_valid = 1'b0;
        bus.store_commit_ready = 1'b0;
        #1;
        tests_run++;
        if (bus.instret !== 64'd4 || bus.rf_we !== 1'b0 || bus.store_commit_valid !== 1'b0) begin
            tests_failed++; $display("FAIL store_retired: got instret=%0d we=%0h scv=%0h expected 4 0 0", bus.instret, bus.rf_we, bus.store_commit_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_exception();
        bus.rob_empty = 1'b0;
        // cause 2 = illegal instruction
        set_entry(32'h3004, 1'b1, 5'd9, 32'hdead, 1'b1, 5'd2, 1'b0);
        #1;
        tests_run++;
        if (bus.retire_ready !== 1'b1 || bus.store_commit_valid !== 1'b0) begin
            tests_failed++; $display("FAIL exc_accept: got rdy=%0h scv=%0h expected 1 0", bus.retire_ready, bus.store_commit_valid);
        end
        @(negedge clk);
        // Younger store offered while trapping/draining must be refused.
        set_entry(32'h3008, 1'b1, 5'd3, 32'd1, 1'b0, 5'd0, 1'b1);
        bus.store_commit_ready = 1'b1;
        #1;
        tests_run++;
        if (bus.flush !== 1'b1 || bus.trap_valid !== 1'b1) begin
            tests_failed++; $display("FAIL trap_pulse: got flush=%0h trap=%0h expected 1 1", bus.flush, bus.trap_valid);
        end
        tests_run++;
        if (bus.trap_epc !== 32'h3004 || bus.trap_cause !== 5'd2) begin
            tests_failed++; $display("FAIL trap_info: got epc=%h cause=%0d expected 00003004 2", bus.trap_epc, bus.trap_cause);
        end
        tests_run++;
        if (bus.rf_we !== 1'b0 || bus.instret !== 64'd4 || bus.retire_ready !== 1'b0) begin
            tests_failed++; $display("FAIL trap_side: got we=%0h instret=%0d rdy=%0h expected 0 4 0", bus.rf_we, bus.instret, bus.retire_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            tests_run++;
            if (bus.retire_ready !== 1'b0 || bus.store_commit_valid !== 1'b0 || bus.flush !== 1'b0 || bus.instret !== 64'd4) begin
                tests_failed++; $display("FAIL drain[%0d]: got rdy=%0h scv=%0h flush=%0h instret=%0d expected 0 0 0 4", i, bus.retire_ready, bus.store_commit_valid, bus.flush, bus.instret);
            end
        end
        bus.retire_valid = 1'b0;
        bus.store_commit_ready = 1'b0;
        bus.rob_empty = 1'b1;
        @(negedge clk);
        bus.rob_empty = 1'b0;
        #1;
        tests_run++;
        if (bus.retire_ready !== 1'b1 || bus.instret !== 64'd4 || bus.rf_we !== 1'b0) begin
            tests_failed++; $display("FAIL drain_exit: got rdy=%0h instret=%0d we=%0h expected 1 4 0", bus.retire_ready, bus.instret, bus.rf_we);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] r;
        r = 5'd2;
        set_entry(32'h5000, 1'b1, r, {27'd0, r} * 32'd16, 1'b0, 5'd0, 1'b0);
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            tests_run++;
            if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'(k) || bus.rf_wdata !== 32'(k * 16) || bus.instret !== 64'(4 + k - 1)) begin
                tests_failed++; $display("FAIL b2b[x%0d]: got we=%0h addr=%0d data=%0d instret=%0d expected 1 %0d %0d %0d", k, bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.instret, k, k * 16, 4 + k - 1);
            end
            if (k < 5) begin
                r = 5'(k + 1);
                set_entry(32'h5000 + 32'(4 * (k - 1)), 1'b1, r, {27'd0, r} * 32'd16, 1'b0, 5'd0, 1'b0);
            end else begin
                bus.retire_valid = 1'b0;
            end
        end
        @(negedge clk);
        tests_run++;
        if (bus.rf_we !== 1'b0 || bus.instret !== 64'd8) begin
            tests_failed++; $display("FAIL b2b_end: got we=%0h instret=%0d expected 0 8", bus.rf_we, bus.instret);
        end
    endtask

    task automatic test_reset_in_drain();
        bus.rob_empty = 1'b0;
        set_entry(32'h4000, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0);
        @(negedge clk);
        bus.retire_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.retire_ready !== 1'b0 || bus.trap_epc !== 32'h4000) begin
            tests_failed++; $display("FAIL rd_in_drain: got rdy=%0h epc=%h expected 0 00004000", bus.retire_ready, bus.trap_epc);
        end
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.instret !== 64'd0 || bus.trap_epc !== 32'd0 || bus.trap_cause !== 5'd0 || bus.retire_ready !== 1'b0 || bus.flush !== 1'b0) begin
            tests_failed++; $display("FAIL rd_reset: got instret=%0d epc=%h cause=%0d rdy=%0h flush=%0h expected all 0", bus.instret, bus.trap_epc, bus.trap_cause, bus.retire_ready, bus.flush);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.retire_ready !== 1'b1) begin tests_failed++; $display("FAIL rd_run: got rdy=%0h expected 1", bus.retire_ready); end
        @(negedge clk);
        set_entry(32'h6000, 1'b1, 5'd12, 32'h1234, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        bus.retire_valid = 1'b0;
        tests_run++;
        if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd12 || bus.rf_wdata !== 32'h1234 || bus.instret !== 64'd1) begin
            tests_failed++; $display("FAIL rd_after: got we=%0h addr=%0d data=%h instret=%0d expected 1 12 00001234 1", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.instret);
        end
        @(negedge clk);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_alu();
        test_x0();
        test_store_stall();
        test_exception();
        test_back_to_back();
        test_reset_in_drain();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
